mlp_host_dma: RTL and testbench

MLP_HOST_DMA -- requirements
Module: mlp_host_dma

---
 rtl/mlp_pkg.sv | 15 +
 rtl/mlp_host_dma_counter.sv | 28 ++
 rtl/mlp_host_dma.sv | 196 +++++++++++++++++++
 tb/tb_mlp_host_dma.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared constants and command encoding for the MLP accelerator host DMA.
package mlp_pkg;

    localparam int NumLayers   = 8;
    localparam int Dim         = 16;
    localparam int WeightWords = 2048;
    localparam int XWords      = 256;
    localparam int CntWidth    = $clog2(WeightWords);

    typedef enum logic {
        OpLoad = 1'b0,
        OpRun  = 1'b1
    } cmd_op_e;

endpackage

// File: rtl/mlp_host_dma_counter.sv
// Word index counter: clear has priority, wraps to zero after Limit-1.
module mlp_host_dma_counter #(
    parameter int Limit = 2048,
    parameter int Width = $clog2(Limit)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [Width-1:0] count,
    output logic             will_overflow
);

    localparam logic [Width-1:0] Last = Width'(Limit - 1);

    assign will_overflow = inc && (count == Last);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= will_overflow ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mlp_host_dma.sv
// Host-side DMA for the MLP accelerator: streams weights / input vectors from memory
// and writes results back. Optional cycle counter enabled by MLP_HOST_DMA_PERF_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// Idle      | ready for a command
// ReqInit   | offering init handshake; fire issues the first weight read
// StreamW   | one weight read per cycle, payload follows read data
// ReqStart  | offering start handshake; fire issues the first input read
// StreamX   | one input read per cycle, payload follows read data
// Collect   | write each returned result to dst+j
// Done      | one-cycle completion pulse
module mlp_host_dma
    import mlp_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_op_i,
    input  logic [AddrWidth-1:0] cmd_src_i,
    input  logic [AddrWidth-1:0] cmd_dst_i,
    output logic                 done_o,
    output logic                 mem_ren_o,
    output logic                 mem_wen_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 init_valid_o,
    input  logic                 init_ready_i,
    output logic                 start_valid_o,
    input  logic                 start_ready_i,
    output logic [DataWidth-1:0] payload_o,
    input  logic                 result_valid_i,
    input  logic [DataWidth-1:0] result_data_i
`ifdef MLP_HOST_DMA_PERF_EN
    ,
    output logic [31:0]          perf_cycles_o
`endif
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StReqInit  = 3'd1;
    localparam logic [2:0] StStreamW  = 3'd2;
    localparam logic [2:0] StReqStart = 3'd3;
    localparam logic [2:0] StStreamX  = 3'd4;
    localparam logic [2:0] StCollect  = 3'd5;
    localparam logic [2:0] StDone     = 3'd6;

    localparam logic [CntWidth-1:0] XLast = CntWidth'(XWords - 1);

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [AddrWidth-1:0] src_q;
    logic [AddrWidth-1:0] dst_q;
    logic [CntWidth-1:0]  cnt;
    logic                 cnt_wrap;
    logic                 cnt_inc;
    logic                 cnt_clr;
    logic [AddrWidth-1:0] idx_addr;

    assign idx_addr = AddrWidth'(cnt);

    // Stream states advance every cycle; Collect only on an accepted result.
    assign cnt_inc = (state_q == StStreamW) || (state_q == StStreamX) ||
                     ((state_q == StCollect) && result_valid_i);
    assign cnt_clr = (state_q == StIdle) ||
                     ((state_q == StStreamX) && (cnt == XLast));

    mlp_host_dma_counter #(
        .Limit(WeightWords)
    ) u_word_cnt (
        .clk          (clk_i),
        .rst          (rst_i),
        .inc          (cnt_inc),
        .clr          (cnt_clr),
        .count        (cnt),
        .will_overflow(cnt_wrap)
    );

    // Outputs are forced quiet while rst_i is high so an abort stops strobes at once.
    always_comb begin
        state_d       = state_q;
        cmd_ready_o   = 1'b0;
        done_o        = 1'b0;
        mem_ren_o     = 1'b0;
        mem_wen_o     = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        init_valid_o  = 1'b0;
        start_valid_o = 1'b0;
        payload_o     = '0;
        if (!rst_i) begin
            case (state_q)
                StIdle: begin
                    cmd_ready_o = 1'b1;
                    if (cmd_valid_i) begin
                        state_d = (cmd_op_e'(cmd_op_i) == OpRun) ? StReqStart : StReqInit;
                    end
                end
                StReqInit: begin
                    init_valid_o = 1'b1;
                    if (init_ready_i) begin
                        mem_ren_o  = 1'b1;
                        mem_addr_o = src_q;
                        state_d    = StStreamW;
                    end
                end
                StReqStart: begin
                    start_valid_o = 1'b1;
                    if (start_ready_i) begin
                        mem_ren_o  = 1'b1;
                        mem_addr_o = src_q;
                        state_d    = StStreamX;
                    end
                end
                StStreamW: begin
                    payload_o = mem_rdata_i;
                    if (cnt_wrap) begin
                        state_d = StDone;
                    end else begin
                        mem_ren_o  = 1'b1;
                        mem_addr_o = src_q + idx_addr + AddrWidth'(1);
                    end
                end
                StStreamX: begin
                    payload_o = mem_rdata_i;
                    if (cnt == XLast) begin
                        state_d = StCollect;
                    end else begin
                        mem_ren_o  = 1'b1;
                        mem_addr_o = src_q + idx_addr + AddrWidth'(1);
                    end
                end
                StCollect: begin
                    if (result_valid_i) begin
                        mem_wen_o   = 1'b1;
                        mem_addr_o  = dst_q + idx_addr;
                        mem_wdata_o = result_data_i;
                        if (cnt == XLast) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    done_o  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && cmd_valid_i) begin
                src_q <= cmd_src_i;
                dst_q <= cmd_dst_i;
            end
        end
    end

`ifdef MLP_HOST_DMA_PERF_EN
    logic        fire;
    logic [31:0] run_cycles_q;

    assign fire = ((state_q == StReqInit) && init_ready_i) ||
                  ((state_q == StReqStart) && start_ready_i);

    // run_cycles_q equals cycles elapsed since fire, so it is the latency when in Done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_cycles_q  <= '0;
            perf_cycles_o <= '0;
        end else begin
            if (fire) begin
                run_cycles_q <= 32'd1;
            end else if (state_q != StIdle) begin
                run_cycles_q <= run_cycles_q + 32'd1;
            end
            if (state_q == StDone) begin
                perf_cycles_o <= run_cycles_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mlp_host_dma.sv
// Scoreboard bench for mlp_host_dma: stimulus pushes expected reads/payloads/writes/done,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mlp_host_dma;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_op_i;
    logic [15:0] cmd_src_i;
    logic [15:0] cmd_dst_i;
    logic        done_o;
    logic        mem_ren_o;
    logic        mem_wen_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;
    logic        init_valid_o;
    logic        init_ready_i;
    logic        start_valid_o;
    logic        start_ready_i;
    logic [15:0] payload_o;
    logic        result_valid_i;
    logic [15:0] result_data_i;
`ifdef MLP_HOST_DMA_PERF_EN
    logic [31:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    mlp_host_dma dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_src_i     (cmd_src_i),
        .cmd_dst_i     (cmd_dst_i),
        .done_o        (done_o),
        .mem_ren_o     (mem_ren_o),
        .mem_wen_o     (mem_wen_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .init_valid_o  (init_valid_o),
        .init_ready_i  (init_ready_i),
        .start_valid_o (start_valid_o),
        .start_ready_i (start_ready_i),
        .payload_o     (payload_o),
        .result_valid_i(result_valid_i),
        .result_data_i (result_data_i)
`ifdef MLP_HOST_DMA_PERF_EN
        ,
        .perf_cycles_o (perf_cycles)
`endif
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic [15:0] mem [0:65535];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_pay[$];
    wr_t         exp_wr[$];
    int          pending_done = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          prev_ren = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: one-cycle read latency, random data on cycles without a read.
    always @(posedge clk) begin
        if (mem_ren_o) mem_rdata_i <= mem[mem_addr_o];
        else           mem_rdata_i <= 16'($urandom);
        if (mem_wen_o) mem[mem_addr_o] <= mem_wdata_o;
    end

    always @(negedge clk) begin
        logic [15:0] a;
        wr_t w;
        if (rst_i) begin
            check(!mem_ren_o && !mem_wen_o && !done_o, "rst_quiet",
                  {29'd0, mem_ren_o, mem_wen_o, done_o}, 0);
            prev_ren = 1'b0;
        end else begin
            if (mem_ren_o && mem_wen_o) check(0, "ren_wen_both", 1, 0);
            if (mem_ren_o) begin
                if (exp_rd.size() == 0) check(0, "unexpected_read", mem_addr_o, 0);
                else begin
                    a = exp_rd.pop_front();
                    check(mem_addr_o == a, "read_addr", mem_addr_o, a);
                end
            end
            if (prev_ren) begin
                if (exp_pay.size() == 0) check(0, "unexpected_payload", payload_o, 0);
                else begin
                    a = exp_pay.pop_front();
                    check(payload_o == a, "payload", payload_o, a);
                end
            end else begin
                check(payload_o == 16'h0, "payload_idle", payload_o, 0);
            end
            if (mem_wen_o) begin
                if (exp_wr.size() == 0) check(0, "unexpected_write", mem_addr_o, 0);
                else begin
                    w = exp_wr.pop_front();
                    check(mem_addr_o == w.a, "write_addr", mem_addr_o, w.a);
                    check(mem_wdata_o == w.d, "write_data", mem_wdata_o, w.d);
                end
            end
            if (done_o) begin
                if (pending_done == 0) check(0, "unexpected_done", 1, 0);
                else begin
                    pending_done--;
                    check(1'b1, "done", 1, 1);
                end
            end
            prev_ren = mem_ren_o;
        end
    end

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((exp_rd.size() != 0 || exp_pay.size() != 0 || exp_wr.size() != 0 ||
                pending_done != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(t < budget, "drain_timeout", t, budget);
    endtask

    // rst_at < 0: normal command; otherwise reset at that StreamW word (load only).
    task automatic run_cmd(input bit op, input logic [15:0] src, input logic [15:0] dst,
                           input int delay, input int gap, input int rst_at);
        int   n;
        int   nrd;
        int   npay;
        logic [15:0] a;
        wr_t  w;
        n = op ? 256 : 2048;
        @(posedge clk); #1;
        cmd_op_i    = op;
        cmd_src_i   = src;
        cmd_dst_i   = dst;
        cmd_valid_i = 1'b1;
        @(negedge clk);
        check(cmd_ready_o == 1'b1, "cmd_ready", cmd_ready_o, 1);
        @(posedge clk); #1;
        cmd_src_i = 16'($urandom);
        cmd_dst_i = 16'($urandom);
        cmd_op_i  = 1'($urandom);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check((op ? start_valid_o : init_valid_o) == 1'b1, "hold_valid", d, delay);
            check(cmd_ready_o == 1'b0, "busy_not_ready", cmd_ready_o, 0);
            @(posedge clk); #1;
        end
        cmd_valid_i = 1'b0;
        if (op) start_ready_i = 1'b1;
        else    init_ready_i  = 1'b1;
        nrd  = (rst_at >= 0) ? rst_at + 1 : n;
        npay = (rst_at >= 0) ? rst_at : n;
        for (int k = 0; k < nrd; k++) begin
            a = src + 16'(k);
            exp_rd.push_back(a);
            if (k < npay) exp_pay.push_back(mem[a]);
        end
        if (rst_at < 0 && !op) pending_done++;
        @(negedge clk);
        check((op ? start_valid_o : init_valid_o) == 1'b1, "fire_valid", 0, 1);
        @(posedge clk); #1;
        start_ready_i = 1'b0;
        init_ready_i  = 1'b0;
        if (rst_at >= 0) begin
            repeat (rst_at) @(posedge clk);
            #1;
            rst_i = 1'b1;
            @(posedge clk); #1;
            rst_i = 1'b0;
            @(negedge clk);
            check(cmd_ready_o == 1'b1, "abort_idle_ready", cmd_ready_o, 1);
            check(!init_valid_o && !done_o, "abort_quiet", {init_valid_o, done_o}, 0);
            check(exp_rd.size() == 0 && exp_pay.size() == 0, "abort_drain",
                  exp_rd.size() + exp_pay.size(), 0);
            return;
        end
        if (op) begin
            // Results during StreamX must be ignored.
            for (int i = 0; i < 256; i++) begin
                result_valid_i = (i < 200) && ($urandom_range(0, 3) == 0);
                result_data_i  = 16'($urandom);
                @(posedge clk); #1;
            end
            result_valid_i = 1'b0;
            for (int j = 0; j < 256; j++) begin
                while (gap > 0 && $urandom_range(0, 99) < gap) begin
                    result_valid_i = 1'b0;
                    @(posedge clk); #1;
                end
                result_data_i  = 16'($urandom);
                result_valid_i = 1'b1;
                w.a = dst + 16'(j);
                w.d = result_data_i;
                exp_wr.push_back(w);
                if (j == 255) pending_done++;
                @(posedge clk); #1;
            end
            result_valid_i = 1'b0;
        end
        wait_drain(3000);
        for (int p = 0; p < 4; p++) begin
            @(posedge clk); #1;
            result_valid_i = 1'b1;
            result_data_i  = 16'($urandom);
            @(negedge clk);
            check(cmd_ready_o == 1'b1, "idle_ready", cmd_ready_o, 1);
        end
        @(posedge clk); #1;
        result_valid_i = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        rst_i          = 1'b1;
        cmd_valid_i    = 1'b0;
        cmd_op_i       = 1'b0;
        cmd_src_i      = '0;
        cmd_dst_i      = '0;
        init_ready_i   = 1'b0;
        start_ready_i  = 1'b0;
        result_valid_i = 1'b0;
        result_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check(cmd_ready_o == 1'b1, "reset_ready", cmd_ready_o, 1);
        check(!init_valid_o && !start_valid_o && !done_o, "reset_outputs",
              {init_valid_o, start_valid_o, done_o}, 0);
        check(mem_addr_o == 16'h0 && mem_wdata_o == 16'h0, "reset_bus",
              {mem_addr_o, mem_wdata_o}, 0);

        run_cmd(1'b0, 16'h0100, 16'h0000, 0, 0, -1);
        run_cmd(1'b1, 16'h1000, 16'h2000, 0, 0, -1);
        run_cmd(1'b1, 16'($urandom), 16'($urandom), 5, 0, -1);
        run_cmd(1'b1, 16'($urandom), 16'($urandom), 0, 40, -1);
        run_cmd(1'b0, 16'hFFF0, 16'h0000, 2, 0, -1);
        run_cmd(1'b0, 16'($urandom), 16'h0000, 0, 0, 100);
        run_cmd(1'b0, 16'($urandom), 16'h0000, 1, 0, -1);
        run_cmd(1'b1, 16'($urandom), 16'hFFC0, $urandom_range(0, 7), $urandom_range(0, 60), -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
